// File: rtl/dshot_pwm_bridge.sv
// -----------------------------------------------------------------------------
// dshot_pwm_bridge
//   Decodes CHANNELS independent DShot lines, validates each 16-bit frame by
//   its 4-bit CRC, filters DShot commands, and drives one servo-style PWM
//   output per channel. A per-channel watchdog forces the minimum pulse when
//   no valid frame has arrived for TIMEOUT_CYCLES. New pulse widths only take
//   effect at a PWM period boundary, so a pulse is never cut or stretched.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_dshot_in     asynchronous DShot lines, one per channel
//   o_pwm_out      PWM outputs, one per channel
//   o_throttle     last accepted throttle, channel i at [11i+10:11i]
//   o_frame_valid  1-cycle pulse per accepted frame (throttle or command)
//   o_crc_err      1-cycle pulse per complete frame with a bad CRC
//   o_failsafe     high while the channel's watchdog has expired
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dshot_pwm_bridge #(
  parameter int CHANNELS       = 4,
  parameter int BIT_CYCLES     = 27,
  parameter int ONE_THRESH     = 15,
  parameter int GAP_CYCLES     = 54,
  parameter int PWM_PERIOD     = 320000,
  parameter int PULSE_MIN      = 16000,
  parameter int PULSE_SHIFT    = 3,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CHANNELS-1:0]      i_dshot_in,
  output logic [CHANNELS-1:0]      o_pwm_out,
  output logic [11*CHANNELS-1:0]   o_throttle,
  output logic [CHANNELS-1:0]      o_frame_valid,
  output logic [CHANNELS-1:0]      o_crc_err,
  output logic [CHANNELS-1:0]      o_failsafe
);

  localparam int HC_W = $clog2(2*BIT_CYCLES + 1);
  localparam int LC_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // The high/low counters start at 0 on the cycle after the edge is seen, so
  // a line level lasting N cycles leaves the counter at N-1 when the next edge
  // arrives. The limits below are offset accordingly.
  localparam logic [HC_W-1:0] ONE_LIM = HC_W'(ONE_THRESH - 1);
  localparam logic [HC_W-1:0] HI_LIM  = HC_W'(2*BIT_CYCLES - 1);
  localparam logic [LC_W-1:0] GAP_LIM = LC_W'(GAP_CYCLES - 2);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [18:0]     PMIN    = 19'(PULSE_MIN);
  localparam logic [18:0]     PLAST   = 19'(PWM_PERIOD - 1);
  localparam logic [10:0]     T_ARMED = 11'd48;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // DShot checksum: XOR of the three nibbles of throttle+telemetry.
  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_prev;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_dshot_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t            r_state;
    logic [HC_W-1:0]   r_high_cnt;
    logic [LC_W-1:0]   r_low_cnt;
    logic [4:0]        r_bit_cnt;
    logic [14:0]       r_shift;
    logic              r_fv;
    logic              r_ce;
    logic [10:0]       r_thr;
    logic [18:0]       r_target;
    logic [WD_W-1:0]   r_wd;
    logic              r_fs;
    logic [18:0]       r_cnt;
    logic [18:0]       r_active;
    logic              r_pwm;

    logic              w_rise;
    logic              w_fall;
    logic              w_bit;
    logic [15:0]       w_frame;
    logic [10:0]       w_t;
    logic              w_crc_ok;
    logic              w_last;
    logic              w_accept;
    logic [18:0]       w_t_off;
    logic [18:0]       w_target_new;
    logic [18:0]       w_target_eff;

    assign w_rise   = r_sync2[c] & ~r_prev[c];
    assign w_fall   = ~r_sync2[c] & r_prev[c];
    assign w_bit    = (r_high_cnt >= ONE_LIM);
    // Frame as it will look once the bit completing on this falling edge is in.
    assign w_frame  = {r_shift, w_bit};
    assign w_t      = w_frame[15:5];
    assign w_crc_ok = (dshot_crc(w_frame[15:4]) == w_frame[3:0]);
    assign w_last   = (r_state == S_HIGH) && w_fall && (r_bit_cnt == 5'd15);
    assign w_accept = w_last && w_crc_ok;

    assign w_t_off      = (w_t >= T_ARMED) ? (19'(w_t - T_ARMED) << PULSE_SHIFT) : 19'd0;
    assign w_target_new = PMIN + w_t_off;
    // Failsafe overrides the stored target without destroying it.
    assign w_target_eff = r_fs ? PMIN : r_target;

    // Receiver FSM: bit timing, frame assembly, CRC/command filtering.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state    <= S_IDLE;
        r_high_cnt <= '0;
        r_low_cnt  <= '0;
        r_bit_cnt  <= 5'd0;
        r_shift    <= 15'd0;
        r_fv       <= 1'b0;
        r_ce       <= 1'b0;
        r_thr      <= 11'd0;
        r_target   <= PMIN;
      end else begin
        r_fv <= 1'b0;
        r_ce <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state    <= S_HIGH;
              r_high_cnt <= '0;
              r_bit_cnt  <= 5'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_shift <= w_frame[14:0];
              if (r_bit_cnt == 5'd15) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 5'd0;
                if (!w_crc_ok) begin
                  r_ce <= 1'b1;
                end else begin
                  r_fv <= 1'b1;
                  if (w_t == 11'd0) begin
                    r_thr    <= 11'd0;
                    r_target <= PMIN;
                  end else if (w_t >= T_ARMED) begin
                    r_thr    <= w_t;
                    r_target <= w_target_new;
                  end else begin
                    // Command frame: acknowledged but output left alone.
                    r_thr <= r_thr;
                  end
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_low_cnt <= '0;
                r_state   <= S_LOW;
              end
            end else if (r_high_cnt >= HI_LIM) begin
              // Line stuck high longer than two bit times: drop the frame.
              r_state <= S_IDLE;
            end else begin
              r_high_cnt <= r_high_cnt + 1'b1;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_state    <= S_HIGH;
              r_high_cnt <= '0;
            end else if (r_low_cnt >= GAP_LIM) begin
              // Frame gap before 16 bits: partial frame discarded silently.
              r_state <= S_IDLE;
            end else begin
              r_low_cnt <= r_low_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end

    // Watchdog: zeroed in step with each frame_valid, raises failsafe on expiry.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_wd <= '0;
        r_fs <= 1'b0;
      end else if (w_accept) begin
        r_wd <= '0;
        r_fs <= 1'b0;
      end else if (!r_fs) begin
        if (r_wd == WD_LAST) begin
          r_fs <= 1'b1;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end else begin
        r_wd <= r_wd;
      end
    end

    // PWM generator: width latched only at the period wrap.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt    <= 19'd0;
        r_active <= 19'd0;
        r_pwm    <= 1'b0;
      end else begin
        if (r_cnt == PLAST) begin
          r_cnt    <= 19'd0;
          r_active <= w_target_eff;
        end else begin
          r_cnt <= r_cnt + 19'd1;
        end
        r_pwm <= (r_cnt < r_active);
      end
    end

    assign o_pwm_out[c]          = r_pwm;
    assign o_throttle[11*c +: 11] = r_thr;
    assign o_frame_valid[c]      = r_fv;
    assign o_crc_err[c]          = r_ce;
    assign o_failsafe[c]         = r_fs;
  end

endmodule

// File: tb/tb_dshot_pwm_bridge.sv
`timescale 1ns/1ps
module tb_dshot_pwm_bridge;
  localparam int CH     = 4;
  localparam int PERIOD = 4400;
  localparam int PMIN   = 400;
  localparam int PSHIFT = 1;
  localparam int TMO    = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dshot;
  logic [3:0]  pwm;
  logic [43:0] thr;
  logic [3:0]  fv;
  logic [3:0]  ce;
  logic [3:0]  fs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fv_cyc[CH];

  typedef struct {
    int ch;
    bit is_crc;
    int thr;
  } exp_t;
  exp_t sb[$];

  dshot_pwm_bridge #(
    .CHANNELS(CH), .BIT_CYCLES(27), .ONE_THRESH(15), .GAP_CYCLES(54),
    .PWM_PERIOD(PERIOD), .PULSE_MIN(PMIN), .PULSE_SHIFT(PSHIFT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dshot_in(dshot), .o_pwm_out(pwm),
    .o_throttle(thr), .o_frame_valid(fv), .o_crc_err(ce), .o_failsafe(fs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] make_frame(input logic [10:0] t);
    logic [11:0] v;
    v = {t, 1'b0};
    return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
  endfunction

  function automatic int pulse_of(input int t);
    return PMIN + ((t - 48) << PSHIFT);
  endfunction

  function automatic int thr_of(input int i);
    return int'(thr[11*i +: 11]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input bit is_crc, input int t);
    exp_t e;
    e.ch = ch; e.is_crc = is_crc; e.thr = t;
    sb.push_back(e);
  endtask

  // DShot600-style bits: 1 = 20 high / 7 low, 0 = 10 high / 17 low.
  task automatic send_bits(input logic [3:0] mask, input logic [15:0] f,
                           input int nbits, input int tail_low);
    int hi;
    for (int b = 0; b < nbits; b++) begin
      hi = f[15-b] ? 20 : 10;
      for (int k = 0; k < 27; k++) begin
        @(negedge clk);
        dshot = (k < hi) ? mask : 4'b0000;
      end
    end
    for (int k = 0; k < tail_low; k++) begin
      @(negedge clk);
      dshot = 4'b0000;
    end
  endtask

  task automatic measure_pulse(input int ch, input int exp, input string tag);
    int n;
    int w;
    n = 0;
    while (pwm[ch] && n < 2*PERIOD) begin @(negedge clk); n++; end
    n = 0;
    while (!pwm[ch] && n < 2*PERIOD) begin @(negedge clk); n++; end
    w = 0;
    while (pwm[ch] && w < 2*PERIOD) begin @(negedge clk); w++; end
    chk(tag, w, exp);
  endtask

  task automatic count_high(input int ncyc, output int hi);
    hi = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (|pwm) hi++;
    end
  endtask

  initial begin
    int n;
    int hi;
    logic [15:0] f;
    rst   = 1'b1;
    dshot = 4'b0000;

    // Scoreboard monitor: every frame_valid / crc_err pulse pops one entry.
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          for (int i = 0; i < CH; i++) begin
            if (fv[i] || ce[i]) begin
              if (fv[i]) fv_cyc[i] = cyc;
              if (sb.size() == 0) begin
                chk("sb_unexpected", {62'd0, fv[i], ce[i]}, 64'd0);
              end else begin
                e = sb.pop_front();
                chk("sb_ch", i, e.ch);
                chk("sb_crc", ce[i], e.is_crc);
                chk("sb_valid", fv[i], !e.is_crc);
                if (!e.is_crc) chk("sb_thr", thr_of(i), e.thr);
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_thr", thr, 0);
    chk("rst_fv", fv, 0);
    chk("rst_ce", ce, 0);
    chk("rst_fs", fs, 0);
    rst = 1'b0;
    count_high(PERIOD - 4, hi);
    chk("first_period_quiet", hi, 0);
    measure_pulse(0, PMIN, "disarm_pulse");

    // Valid frame 0x82C6 on ch0
    push(0, 1'b0, 1046);
    send_bits(4'b0001, 16'h82C6, 16, 70);
    chk("ch0_drain", sb.size(), 0);
    chk("thr_ch0", thr_of(0), 1046);
    chk("thr_others", thr[43:11], 0);
    measure_pulse(0, pulse_of(1046), "pulse_1046");

    // Bad CRC on ch1
    push(1, 1'b1, 0);
    send_bits(4'b0010, 16'h82C7, 16, 70);
    chk("ch1_drain", sb.size(), 0);
    chk("thr_ch1_crc", thr_of(1), 0);
    chk("thr_ch0_keep", thr_of(0), 1046);
    measure_pulse(1, PMIN, "ch1_pulse_keep");

    // ch2: full throttle, disarm, then command
    push(2, 1'b0, 2047);
    send_bits(4'b0100, make_frame(11'd2047), 16, 70);
    chk("ch2_drain_max", sb.size(), 0);
    chk("thr_ch2_max", thr_of(2), 2047);
    measure_pulse(2, pulse_of(2047), "pulse_2047");
    push(2, 1'b0, 0);
    send_bits(4'b0100, make_frame(11'd0), 16, 70);
    chk("thr_ch2_zero", thr_of(2), 0);
    measure_pulse(2, PMIN, "pulse_disarm");
    push(2, 1'b0, 0);
    send_bits(4'b0100, make_frame(11'd5), 16, 70);
    chk("ch2_drain_cmd", sb.size(), 0);
    chk("thr_ch2_cmd", thr_of(2), 0);
    measure_pulse(2, PMIN, "pulse_after_cmd");

    // Lowest armed throttle on ch3
    push(3, 1'b0, 48);
    send_bits(4'b1000, make_frame(11'd48), 16, 70);
    chk("ch3_drain_48", sb.size(), 0);
    chk("thr_ch3_48", thr_of(3), 48);

    // Partial frame aborted by gap, then a good frame
    f = make_frame(11'd1500);
    send_bits(4'b0001, f, 10, 60);
    chk("partial_silent", sb.size(), 0);
    chk("partial_thr", thr_of(0), 1046);
    push(0, 1'b0, 1500);
    send_bits(4'b0001, f, 16, 70);
    chk("after_partial_drain", sb.size(), 0);
    chk("after_partial_thr", thr_of(0), 1500);

    // Watchdog timeout and recovery on ch0
    push(0, 1'b0, 1046);
    send_bits(4'b0001, 16'h82C6, 16, 70);
    chk("fs_frame_drain", sb.size(), 0);
    chk("fs_clear_before", fs[0], 0);
    n = 0;
    while (!fs[0] && n < TMO + 200) begin @(negedge clk); n++; end
    chk("fs_set", fs[0], 1);
    chk("fs_delay", cyc - fv_cyc[0], TMO);
    measure_pulse(0, PMIN, "fs_pulse");
    chk("fs_ch1_never_valid", fs[1], 1);
    push(0, 1'b0, 1046);
    send_bits(4'b0001, 16'h82C6, 16, 70);
    chk("fs_recover", fs[0], 0);

    // Same frame on all channels at once
    for (int i = 0; i < CH; i++) push(i, 1'b0, 1046);
    send_bits(4'b1111, 16'h82C6, 16, 70);
    chk("simul_drain", sb.size(), 0);
    for (int i = 1; i < CH; i++) chk("simul_cycle", fv_cyc[i], fv_cyc[0]);
    chk("simul_fs", fs, 0);

    // Reset in the middle of a frame and of a pulse
    n = 0;
    while (!pwm[0] && n < 2*PERIOD) begin @(negedge clk); n++; end
    send_bits(4'b1111, 16'h82C6, 8, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pwm_drop", pwm, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_thr", thr, 0);
    chk("rst2_fs", fs, 0);
    chk("rst2_fv", fv, 0);
    chk("rst2_ce", ce, 0);
    count_high(PERIOD - 6, hi);
    chk("rst2_quiet_period", hi, 0);
    measure_pulse(0, PMIN, "rst2_disarm_pulse");
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dshot_pwm_bridge.md
# dshot_pwm_bridge

Multi-channel successor to the single-channel DShot-to-PWM path: decodes CHANNELS independent DShot600 inputs, validates each 16-bit frame by CRC, and drives one servo-style PWM output per channel. Adds features the single-channel path lacks: CRC checking, DShot command filtering, a per-channel failsafe timeout, and glitch-free PWM updates at period boundaries. Instantiated once in the top level between the flight-controller header pins and the ESC/servo output pins.

## Interface
- CHANNELS, 4, number of independent DShot-in / PWM-out lanes
- BIT_CYCLES, 27, clk cycles per DShot bit (DShot600 at 16 MHz)
- ONE_THRESH, 15, minimum high time in cycles for a bit to decode as 1
- GAP_CYCLES, 54, low time in cycles that ends or aborts a frame
- PWM_PERIOD, 320000, PWM period in cycles (50 Hz)
- PULSE_MIN, 16000, pulse width in cycles for throttle 48 / disarm (1000 us)
- PULSE_SHIFT, 3, left-shift applied to (throttle-48) to get extra pulse cycles
- TIMEOUT_CYCLES, 1600000, cycles without a valid frame before failsafe (100 ms)
- clk  in  1  system clock, 16 MHz
- rst  in  1  reset, synchronous, active-high
- dshot_in  in  CHANNELS  asynchronous DShot lines, one per channel
- pwm_out  out  CHANNELS  PWM outputs
- throttle  out  11*CHANNELS  last accepted throttle per channel, channel i at [11i+10:11i]
- frame_valid  out  CHANNELS  1-cycle pulse per accepted frame
- crc_err  out  CHANNELS  1-cycle pulse per 16-bit frame that fails CRC
- failsafe  out  CHANNELS  high while channel is in timeout

## Operation
- Each dshot_in bit passes a 2-flop synchronizer; all decode uses the synchronized value and its previous sample for edge detection.
- Per-channel receiver FSM: IDLE -> HIGH (rising edge; clear high counter) -> LOW (falling edge; shift in bit = high_cnt >= ONE_THRESH, bit count +1) -> HIGH on next rising edge.
- High counter saturates at 2*BIT_CYCLES; high time > 2*BIT_CYCLES aborts the frame -> IDLE, no pulses.
- Low time >= GAP_CYCLES in LOW with bit count != 16 aborts -> IDLE silently.
- On the 16th falling edge: frame F[15:0] MSB first; v = F[15:4]; crc = v[3:0]^v[7:4]^v[11:8]. Mismatch -> crc_err pulse. Match -> check throttle t = F[15:5]:
  - t = 0: accept as disarm; throttle <= 0; pulse target = PULSE_MIN.
  - 1 <= t <= 47: command; frame_valid pulses, throttle/pulse target unchanged.
  - t >= 48: throttle <= t; pulse target = PULSE_MIN + ((t-48) << PULSE_SHIFT) (default max 31992).
- Telemetry bit F[4] is ignored. After the 16th bit, FSM returns to IDLE and waits for line low >= GAP_CYCLES... no: returns to IDLE immediately; next rising edge starts a new frame.
- Watchdog per channel: cleared by every frame_valid; counts to TIMEOUT_CYCLES, then failsafe = 1 and pulse target forced to PULSE_MIN. Next frame_valid clears failsafe.
- PWM generator per channel: 19-bit period counter 0..PWM_PERIOD-1 wrapping; pwm_out = (cnt < active_width). active_width loads from pulse target only when cnt wraps to 0.

## Timing
- Reset: pwm_out = 0, throttle = 0, frame_valid = 0, crc_err = 0, failsafe = 0, all FSMs IDLE, counters 0, pulse target = PULSE_MIN, active_width = 0 (first period after reset outputs no pulse).
- Input-to-decode latency: 2 cycles synchronizer + 1 cycle edge detect.
- frame_valid / crc_err assert the cycle after the registered 16th falling edge; throttle updates same cycle as frame_valid.
- New pulse target affects pwm_out at the next period wrap: latency 1..PWM_PERIOD cycles; widths never change mid-pulse.
- failsafe rises exactly TIMEOUT_CYCLES after the last frame_valid (or after reset).
- Channels are fully independent; simultaneous frames on all channels each produce their own pulses in the same cycle.
- rst mid-frame discards the partial frame; rst mid-pulse drops pwm_out low on the next cycle.

## Test plan
- Frame 0x82C6 (t=1046, CRC 6) on ch0 -> frame_valid[0] once, throttle[10:0]=1046, pulse 23984 cycles from next period wrap; other channels unchanged.
- Frame 0x82C7 (bad CRC) on ch1 -> crc_err[1] once, no frame_valid, throttle/pwm unchanged.
- t=2047 frame then t=0 frame on ch2 -> pulse 31992 cycles, then 16000 cycles; throttle 0; command t=5 afterwards -> frame_valid but pulse stays 16000.
- 10 bits then line low 60 cycles, then valid frame -> no pulses for partial, valid frame accepted normally.
- Valid frame, then silence 1600000 cycles -> failsafe=1, pulse 16000; next valid frame clears failsafe.
- Same valid frame on all 4 channels in the same cycle, rst asserted mid-second frame -> 4 simultaneous frame_valid; after rst all outputs reset values, one period with no pulse.
